// File: rtl/alu_op_sequencer.sv
// Control sequencer for a single-bus ALU datapath: steps one register-to-register
// operation through operand load, execute and write-back, pulsing done at the end.
module alu_op_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [3:0]          op,
  input  logic [IDX_W-1:0]    src_a,
  input  logic [IDX_W-1:0]    src_b,
  input  logic [IDX_W-1:0]    dst,
  output logic [NUM_REGS-1:0] r_out,
  output logic [NUM_REGS-1:0] r_in,
  output logic                y_in,
  output logic                z_in,
  output logic                z_out,
  output logic [3:0]          alu_op,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // state  | meaning
  // IDLE   | waiting for start, no strobes
  // LOAD_A | src_a drives bus, Y loads
  // EXEC   | src_b drives bus (none for NOT), ALU result into Z
  // WB     | Z drives bus, dst loads
  // FIN    | done pulse, err if the op code was illegal
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_FIN    = 3'd4
  } state_e;

  localparam logic [3:0]          OP_NOT  = 4'd2;
  localparam logic [3:0]          OP_MAX  = 4'd4;
  localparam logic [NUM_REGS-1:0] ONE_HOT = {{(NUM_REGS-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [IDX_W-1:0] src_a_q, src_a_d;
  logic [IDX_W-1:0] src_b_q, src_b_d;
  logic [IDX_W-1:0] dst_q, dst_d;
  logic             illegal_q, illegal_d;

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      dst_q     <= dst_d;
      illegal_q <= illegal_d;
    end
  end

  // Request fields are captured only on acceptance, so inputs are free to move afterwards.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    dst_d     = dst_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          src_a_d = src_a;
          src_b_d = src_b;
          dst_d   = dst;
          if (op <= OP_MAX) begin
            illegal_d = 1'b0;
            state_d   = S_LOAD_A;
          end else begin
            illegal_d = 1'b1;
            state_d   = S_FIN;
          end
        end
      end
      S_LOAD_A: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FIN;
      S_FIN: begin
        illegal_d = 1'b0;
        state_d   = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    r_out  = '0;
    r_in   = '0;
    y_in   = 1'b0;
    z_in   = 1'b0;
    z_out  = 1'b0;
    alu_op = '0;
    busy   = (state_q != S_IDLE);
    done   = 1'b0;
    err    = 1'b0;
    case (state_q)
      S_LOAD_A: begin
        r_out = ONE_HOT << src_a_q;
        y_in  = 1'b1;
      end
      S_EXEC: begin
        r_out  = (op_q == OP_NOT) ? '0 : (ONE_HOT << src_b_q);
        z_in   = 1'b1;
        alu_op = op_q;
      end
      S_WB: begin
        z_out = 1'b1;
        r_in  = ONE_HOT << dst_q;
      end
      S_FIN: begin
        done = 1'b1;
        err  = illegal_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table, directed corner sequences
// and randomized traffic, all compared cycle by cycle against a schedule model.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        clear, start;
  logic [3:0]  op, src_a, src_b, dst;
  logic [15:0] r_out, r_in;
  logic        y_in, z_in, z_out, busy, done, err;
  logic [3:0]  alu_op;

  always #5 clock = ~clock;

  alu_op_sequencer #(.NUM_REGS(16), .IDX_W(4)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .dst(dst),
    .r_out(r_out), .r_in(r_in), .y_in(y_in), .z_in(z_in), .z_out(z_out),
    .alu_op(alu_op), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic        y_in, z_in, z_out;
    logic [3:0]  alu_op;
    logic        busy, done, err;
  } outs_t;

  typedef struct {
    logic [3:0]  op, a, b, d;
    int          busy_cycles;
    bit          err;
    logic [15:0] rin, rout_exec;
  } vec_t;

  // Model: the outputs still owed for the request in flight, one entry per cycle.
  outs_t exp_q[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  int          busy_cnt;
  bit          done_seen, err_at_done;
  logic [15:0] rin_or, rout_exec;
  int          done_cyc[$];

  function automatic logic [15:0] oh(input logic [3:0] i);
    logic [15:0] one;
    one = 16'h0001;
    return one << i;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic model_edge();
    outs_t s;
    if (!clear) exp_q.delete();
    else if (exp_q.size() != 0) void'(exp_q.pop_front());
    else if (start) begin
      if (op > 4'd4) begin
        s = '0; s.busy = 1'b1; s.done = 1'b1; s.err = 1'b1; exp_q.push_back(s);
      end else begin
        s = '0; s.busy = 1'b1; s.r_out = oh(src_a); s.y_in = 1'b1; exp_q.push_back(s);
        s = '0; s.busy = 1'b1; s.r_out = (op == 4'd2) ? 16'h0000 : oh(src_b);
        s.z_in = 1'b1; s.alu_op = op; exp_q.push_back(s);
        s = '0; s.busy = 1'b1; s.z_out = 1'b1; s.r_in = oh(dst); exp_q.push_back(s);
        s = '0; s.busy = 1'b1; s.done = 1'b1; exp_q.push_back(s);
      end
    end
  endtask

  task automatic sample_and_check();
    outs_t act, exp;
    act.r_out = r_out; act.r_in = r_in; act.y_in = y_in; act.z_in = z_in;
    act.z_out = z_out; act.alu_op = alu_op; act.busy = busy; act.done = done; act.err = err;
    exp = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("cycle_outputs", 64'(act), 64'(exp));
    check("onehot_r_out", 64'($countones(r_out) <= 1), 64'(1));
    check("onehot_r_in", 64'($countones(r_in) <= 1), 64'(1));
    check("bus_conflict", 64'((r_out != 16'h0) && z_out), 64'(0));
    if (busy) busy_cnt++;
    if (done) begin
      done_seen   = 1'b1;
      err_at_done = err;
      done_cyc.push_back(cyc);
    end
    rin_or |= r_in;
    if (z_in) rout_exec = r_out;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    cyc++;
    @(negedge clock);
    sample_and_check();
  endtask

  task automatic clear_trackers();
    busy_cnt = 0; done_seen = 1'b0; err_at_done = 1'b0; rin_or = '0; rout_exec = '0;
  endtask

  // One request; leaves the bench in the first IDLE cycle so a following call is back-to-back.
  task automatic run_one(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d);
    int n;
    clear_trackers();
    op = o; src_a = a; src_b = b; dst = d; start = 1'b1;
    step();
    start = 1'b0;
    op = 4'($urandom); src_a = 4'($urandom); src_b = 4'($urandom); dst = 4'($urandom);
    n = 0;
    while (!done_seen && n < 10) begin
      step();
      n++;
    end
    if (!done_seen) check("done_timeout", 64'(0), 64'(1));
    step();
  endtask

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'd3,  4'd2,  4'd5,  4'd7,  4, 1'b0, 16'h0080, 16'h0020};
    vecs[1] = '{4'd2,  4'd1,  4'd9,  4'd1,  4, 1'b0, 16'h0002, 16'h0000};
    vecs[2] = '{4'd9,  4'd0,  4'd0,  4'd0,  1, 1'b1, 16'h0000, 16'h0000};
    vecs[3] = '{4'd0,  4'd3,  4'd3,  4'd3,  4, 1'b0, 16'h0008, 16'h0008};
    vecs[4] = '{4'd4,  4'd15, 4'd0,  4'd15, 4, 1'b0, 16'h8000, 16'h0001};
    vecs[5] = '{4'd1,  4'd0,  4'd15, 4'd0,  4, 1'b0, 16'h0001, 16'h8000};
    vecs[6] = '{4'd15, 4'd4,  4'd4,  4'd4,  1, 1'b1, 16'h0000, 16'h0000};
    vecs[7] = '{4'd5,  4'd1,  4'd2,  4'd3,  1, 1'b1, 16'h0000, 16'h0000};

    clear = 1'b0; start = 1'b1; op = 4'd3; src_a = 4'd1; src_b = 4'd2; dst = 4'd3;
    clear_trackers();
    step();
    step();
    clear = 1'b1; start = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_one(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d);
      check($sformatf("vec%0d_busy_cycles", i), 64'(busy_cnt), 64'(vecs[i].busy_cycles));
      check($sformatf("vec%0d_err", i), 64'(err_at_done), 64'(vecs[i].err));
      check($sformatf("vec%0d_r_in", i), 64'(rin_or), 64'(vecs[i].rin));
      check($sformatf("vec%0d_r_out_exec", i), 64'(rout_exec), 64'(vecs[i].rout_exec));
    end

    // start held for ten edges: accepted at the first edge and again five edges later.
    begin
      int s0;
      done_cyc.delete();
      clear_trackers();
      op = 4'd4; src_a = 4'd1; src_b = 4'd2; dst = 4'd3; start = 1'b1;
      s0 = cyc + 1;
      for (int k = 0; k < 10; k++) begin
        step();
        src_a = 4'($urandom); src_b = 4'($urandom); dst = 4'($urandom);
      end
      start = 1'b0;
      repeat (6) step();
      check("held_start_done_count", 64'(done_cyc.size()), 64'(2));
      if (done_cyc.size() == 2) begin
        // done is visible in the cycle that ends at edge N+4, i.e. sampled after edge N+3.
        check("held_start_first_done", 64'(done_cyc[0] - s0), 64'(3));
        check("held_start_second_done", 64'(done_cyc[1] - s0), 64'(8));
      end
    end

    // Abort an add in EXEC: no write-back and no done afterwards.
    op = 4'd3; src_a = 4'd2; src_b = 4'd5; dst = 4'd7; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("abort_in_exec", 64'(z_in), 64'(1));
    clear = 1'b0;
    clear_trackers();
    step();
    clear = 1'b1;
    repeat (4) step();
    check("abort_no_done", 64'(done_seen), 64'(0));
    check("abort_no_r_in", 64'(rin_or), 64'(0));
    run_one(4'd3, 4'd2, 4'd5, 4'd7);
    check("after_abort_busy", 64'(busy_cnt), 64'(4));
    check("after_abort_r_in", 64'(rin_or), 64'(16'h0080));

    // Back-to-back requests: second done exactly five cycles after the first.
    done_cyc.delete();
    run_one(4'd0, 4'd6, 4'd7, 4'd8);
    run_one(4'd1, 4'd9, 4'd10, 4'd11);
    check("b2b_done_count", 64'(done_cyc.size()), 64'(2));
    if (done_cyc.size() == 2)
      check("b2b_done_spacing", 64'(done_cyc[1] - done_cyc[0]), 64'(5));

    for (int k = 0; k < 400; k++) begin
      clear = ($urandom_range(0, 39) != 0);
      start = ($urandom_range(0, 2) != 0);
      op    = 4'($urandom_range(0, 7));
      src_a = 4'($urandom); src_b = 4'($urandom); dst = 4'($urandom);
      step();
    end
    clear = 1'b1; start = 1'b0;
    repeat (6) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
